// File: rtl/net_tx_framer.sv
// Net-side AXI-Stream framer: slices descriptor-length frames into beats, builds tlast/tkeep, buffers in a FIFO.
// Optional frame/beat/stall counters are present when NET_TX_STATS_EN is defined.
module net_tx_framer #(
  parameter int ROWS            = 32,
  parameter int INPUT_LENGTH    = 16,
  parameter int AXIS_DATA_WIDTH = ROWS * INPUT_LENGTH,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_DEST_WIDTH = 8,
  parameter int AXIS_ID_WIDTH   = 7,
  parameter int AXIS_USER_WIDTH = 8,
  parameter int LEN_WIDTH       = 20,
  parameter logic [AXIS_DEST_WIDTH-1:0] DEST_VALUE = 'hbf,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       net_tstart,
  input  logic [LEN_WIDTH-1:0]       net_tdesc_len,
  input  logic [AXIS_DATA_WIDTH-1:0] net_data_in,
  input  logic                       net_valid_in,
  output logic                       net_tx_rdy,
  output logic [AXIS_DATA_WIDTH-1:0] m_net_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_net_axis_tkeep,
  output logic                       m_net_axis_tlast,
  output logic                       m_net_axis_tvalid,
  input  logic                       m_net_axis_tready,
  output logic [AXIS_DEST_WIDTH-1:0] m_net_axis_tdest,
  output logic [AXIS_ID_WIDTH-1:0]   m_net_axis_tid,
  output logic [AXIS_USER_WIDTH-1:0] m_net_axis_tuser,
  output logic                       net_tx_busy,
  output logic                       net_tx_done,
  output logic                       net_tx_err
`ifdef NET_TX_STATS_EN
  ,
  output logic [31:0]                stat_frames,
  output logic [31:0]                stat_beats,
  output logic [31:0]                stat_stall
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [LEN_WIDTH-1:0] KB_LEN = LEN_WIDTH'(AXIS_KEEP_WIDTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                     state;
  logic [LEN_WIDTH-1:0]       rem;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [PW-1:0]              fill;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic                       last_beat;
  logic [AXIS_KEEP_WIDTH-1:0] keep_next;

  logic [AXIS_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [AXIS_KEEP_WIDTH-1:0] mem_keep [FIFO_DEPTH];
  logic                       mem_last [FIFO_DEPTH];

  assign fill       = wr_ptr - rd_ptr;
  assign fifo_full  = (fill == DEPTH_P);
  assign fifo_empty = (wr_ptr == rd_ptr);

  // Ready deliberately ignores a same-cycle pop: no push-through when full.
  assign net_tx_rdy = (state == LOAD) && !fifo_full;
  assign push       = net_tx_rdy && net_valid_in;
  assign pop        = !fifo_empty && m_net_axis_tready;
  assign last_beat  = (rem <= KB_LEN);

  always_comb begin
    keep_next = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      keep_next[i] = (LEN_WIDTH'(i) < rem);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= net_data_in;
      mem_keep[wr_ptr[AW-1:0]] <= keep_next;
      mem_last[wr_ptr[AW-1:0]] <= last_beat;
    end
  end

  // Head entry is masked while empty so every output reads zero out of reset.
  assign m_net_axis_tvalid = !fifo_empty;
  assign m_net_axis_tdata  = fifo_empty ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign m_net_axis_tkeep  = fifo_empty ? '0 : mem_keep[rd_ptr[AW-1:0]];
  assign m_net_axis_tlast  = fifo_empty ? 1'b0 : mem_last[rd_ptr[AW-1:0]];
  assign m_net_axis_tdest  = DEST_VALUE;
  assign m_net_axis_tid    = '0;
  assign m_net_axis_tuser  = '0;
  assign net_tx_busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      net_tx_done <= 1'b0;
      net_tx_err  <= 1'b0;
`ifdef NET_TX_STATS_EN
      stat_frames <= '0;
      stat_beats  <= '0;
      stat_stall  <= '0;
`endif
    end else begin
      net_tx_done <= 1'b0;
      net_tx_err  <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
`ifdef NET_TX_STATS_EN
      if (pop) stat_beats <= stat_beats + 32'd1;
      if (pop && m_net_axis_tlast) stat_frames <= stat_frames + 32'd1;
      if (m_net_axis_tvalid && !m_net_axis_tready) stat_stall <= stat_stall + 32'd1;
`endif
      case (state)
        IDLE: begin
          if (net_tstart) begin
            if (net_tdesc_len != '0) begin
              rem   <= net_tdesc_len;
              state <= LOAD;
            end else begin
              net_tx_done <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (net_tstart) net_tx_err <= 1'b1;
          if (push) begin
            if (last_beat) begin
              rem   <= '0;
              state <= DRAIN;
            end else begin
              rem <= rem - KB_LEN;
            end
          end
        end
        DRAIN: begin
          if (net_tstart) net_tx_err <= 1'b1;
          // The final beat is the only tlast entry left in the FIFO here.
          if (pop && m_net_axis_tlast) begin
            state       <= IDLE;
            net_tx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_net_tx_framer.sv
// Directed bench for net_tx_framer: framing, tkeep/tlast, backpressure, zero length, errors, reset.
module tb_net_tx_framer;

  localparam int DW = 512;
  localparam int KW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            net_tstart = 1'b0;
  logic [19:0]     net_tdesc_len = '0;
  logic [DW-1:0]   net_data_in = '0;
  logic            net_valid_in = 1'b0;
  logic            net_tx_rdy;
  logic [DW-1:0]   m_net_axis_tdata;
  logic [KW-1:0]   m_net_axis_tkeep;
  logic            m_net_axis_tlast;
  logic            m_net_axis_tvalid;
  logic            m_net_axis_tready = 1'b1;
  logic [7:0]      m_net_axis_tdest;
  logic [6:0]      m_net_axis_tid;
  logic [7:0]      m_net_axis_tuser;
  logic            net_tx_busy;
  logic            net_tx_done;
  logic            net_tx_err;
`ifdef NET_TX_STATS_EN
  logic [31:0]     stat_frames;
  logic [31:0]     stat_beats;
  logic [31:0]     stat_stall;
`endif

  net_tx_framer dut (
    .clk(clk), .rst(rst),
    .net_tstart(net_tstart), .net_tdesc_len(net_tdesc_len),
    .net_data_in(net_data_in), .net_valid_in(net_valid_in), .net_tx_rdy(net_tx_rdy),
    .m_net_axis_tdata(m_net_axis_tdata), .m_net_axis_tkeep(m_net_axis_tkeep),
    .m_net_axis_tlast(m_net_axis_tlast), .m_net_axis_tvalid(m_net_axis_tvalid),
    .m_net_axis_tready(m_net_axis_tready), .m_net_axis_tdest(m_net_axis_tdest),
    .m_net_axis_tid(m_net_axis_tid), .m_net_axis_tuser(m_net_axis_tuser),
    .net_tx_busy(net_tx_busy), .net_tx_done(net_tx_done), .net_tx_err(net_tx_err)
`ifdef NET_TX_STATS_EN
    , .stat_frames(stat_frames), .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t beats[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    err_cnt = 0;
  int    last_cyc = 0;
  int    done_cyc = 0;
  int    acc_cnt = 0;
  int    stall_cnt = 0;
  bit    busy_seen = 1'b0;

  always @(posedge clk) cyc++;

  // Inputs only change #1 after posedge, so the negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (m_net_axis_tvalid && m_net_axis_tready) begin
      beats.push_back('{d: m_net_axis_tdata, k: m_net_axis_tkeep, l: m_net_axis_tlast});
      if (m_net_axis_tlast) last_cyc = cyc;
    end
    if (m_net_axis_tvalid && !m_net_axis_tready) stall_cnt++;
    if (net_tx_done) begin done_cnt++; done_cyc = cyc; end
    if (net_tx_err) err_cnt++;
    if (net_tx_busy) busy_seen = 1'b1;
  end

  function automatic logic [DW-1:0] mk(input int f, input int i);
    logic [31:0] w;
    w = {f[15:0], i[15:0]};
    return {16{w}};
  endfunction

  task automatic clear_mon();
    beats.delete();
    done_cnt = 0; err_cnt = 0; busy_seen = 1'b0; acc_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; net_tstart = 1'b0; net_valid_in = 1'b0; m_net_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    stall_cnt = 0;
  endtask

  task automatic send_frame(input int len, input int f, input int err_at);
    int  n;
    int  k;
    int  budget;
    bit  inj;
    logic acc;
    n = (len + KW - 1) / KW; k = 0; budget = 0; inj = 1'b0;
    @(posedge clk); #1;
    net_tstart = 1'b1; net_tdesc_len = 20'(len);
    @(posedge clk); #1;
    net_tstart = 1'b0;
    while (k < n && budget < 300) begin
      net_valid_in = 1'b1;
      net_data_in  = mk(f, k);
      if (k == err_at && !inj) begin
        net_tstart = 1'b1; net_tdesc_len = 20'd64; inj = 1'b1;
      end
      @(negedge clk);
      acc = net_tx_rdy;
      @(posedge clk); #1;
      net_tstart = 1'b0;
      if (acc) begin k++; acc_cnt++; end
      budget++;
    end
    net_valid_in = 1'b0;
    checks++;
    if (k !== n) begin
      errors++; $display("FAIL send_timeout: accepted %0d beats, expected %0d", k, n);
    end
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (beats.size() < n && t < 300) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (beats.size() !== n) begin
      errors++; $display("FAIL beat_count: got %0d expected %0d", beats.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (m_net_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", m_net_axis_tvalid); end
    checks++; if (net_tx_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b expected 0", net_tx_rdy); end
    checks++; if (net_tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", net_tx_busy); end
    checks++; if (net_tx_done !== 1'b0 || net_tx_err !== 1'b0) begin errors++; $display("FAIL rst_pulses: got done=%b err=%b expected 0 0", net_tx_done, net_tx_err); end
    checks++; if (m_net_axis_tdest !== 8'hbf) begin errors++; $display("FAIL rst_tdest: got %h expected bf", m_net_axis_tdest); end
    checks++; if (m_net_axis_tid !== 7'd0 || m_net_axis_tuser !== 8'd0) begin errors++; $display("FAIL rst_tid_tuser: got %h %h expected 0 0", m_net_axis_tid, m_net_axis_tuser); end
    checks++; if (m_net_axis_tkeep !== '0 || m_net_axis_tlast !== 1'b0 || m_net_axis_tdata !== '0) begin errors++; $display("FAIL rst_head: got keep=%h last=%b expected 0 0", m_net_axis_tkeep, m_net_axis_tlast); end
    do_reset();
  endtask

  task automatic test_two_beat();
    clear_mon();
    m_net_axis_tready = 1'b1;
    send_frame(128, 1, -1);
    wait_beats(2);
    if (beats.size() == 2) begin
      checks++; if (beats[0].d !== mk(1, 0) || beats[1].d !== mk(1, 1)) begin errors++; $display("FAIL two_data: got %h expected %h", beats[1].d, mk(1, 1)); end
      checks++; if (beats[0].k !== {KW{1'b1}} || beats[0].l !== 1'b0) begin errors++; $display("FAIL two_b0: got keep=%h last=%b expected all ones, 0", beats[0].k, beats[0].l); end
      checks++; if (beats[1].k !== {KW{1'b1}} || beats[1].l !== 1'b1) begin errors++; $display("FAIL two_b1: got keep=%h last=%b expected all ones, 1", beats[1].k, beats[1].l); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL two_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc - last_cyc !== 1) begin errors++; $display("FAIL two_done_latency: got %0d expected 1", done_cyc - last_cyc); end
    checks++; if (net_tx_busy !== 1'b0 || err_cnt !== 0) begin errors++; $display("FAIL two_idle: got busy=%b err=%0d expected 0 0", net_tx_busy, err_cnt); end
  endtask

  task automatic test_partial();
    clear_mon();
    send_frame(100, 2, -1);
    wait_beats(2);
    if (beats.size() == 2) begin
      checks++; if (beats[0].k !== {KW{1'b1}} || beats[0].l !== 1'b0) begin errors++; $display("FAIL part_b0: got keep=%h last=%b expected all ones, 0", beats[0].k, beats[0].l); end
      checks++; if (beats[1].k !== 64'h0000_000F_FFFF_FFFF) begin errors++; $display("FAIL part_keep: got %h expected 0000000fffffffff", beats[1].k); end
      checks++; if (beats[1].l !== 1'b1 || beats[1].d !== mk(2, 1)) begin errors++; $display("FAIL part_b1: got last=%b expected 1 with data beat 1", beats[1].l); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL part_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    m_net_axis_tready = 1'b0;
    fork
      send_frame(512, 3, -1);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (m_net_axis_tvalid) begin
            checks++;
            if (m_net_axis_tdata !== mk(3, 0) || m_net_axis_tlast !== 1'b0) begin
              errors++; $display("FAIL bp_stable: got %h expected %h", m_net_axis_tdata, mk(3, 0));
            end
          end
        end
        checks++; if (net_tx_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_low: got %b expected 0", net_tx_rdy); end
        checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL bp_buffered: got %0d expected 4", acc_cnt); end
        checks++; if (m_net_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid: got %b expected 1", m_net_axis_tvalid); end
        @(posedge clk); #1;
        m_net_axis_tready = 1'b1;
      end
    join
    wait_beats(8);
    for (int i = 0; i < beats.size(); i++) begin
      checks++;
      if (beats[i].d !== mk(3, i) || beats[i].k !== {KW{1'b1}} || beats[i].l !== (i == 7)) begin
        errors++; $display("FAIL bp_order[%0d]: got last=%b keep=%h expected last=%b keep all ones", i, beats[i].l, beats[i].k, (i == 7));
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    @(posedge clk); #1;
    net_tstart = 1'b1; net_tdesc_len = 20'd0;
    @(posedge clk); #1;
    net_tstart = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done: got %0d expected 1", done_cnt); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy_seen); end
    checks++; if (beats.size() !== 0 || m_net_axis_tvalid !== 1'b0) begin errors++; $display("FAIL zero_beats: got %0d beats expected 0", beats.size()); end
  endtask

  task automatic test_err_and_reset();
    clear_mon();
    m_net_axis_tready = 1'b1;
    send_frame(256, 5, 1);
    wait_beats(4);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL err_pulse: got %0d expected 1", err_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL err_done: got %0d expected 1", done_cnt); end
    for (int i = 0; i < beats.size(); i++) begin
      checks++;
      if (beats[i].d !== mk(5, i) || beats[i].l !== (i == 3)) begin
        errors++; $display("FAIL err_frame[%0d]: got last=%b expected %b", i, beats[i].l, (i == 3));
      end
    end
    // Reset in the middle of a stalled frame
    clear_mon();
    m_net_axis_tready = 1'b0;
    @(posedge clk); #1;
    net_tstart = 1'b1; net_tdesc_len = 20'd512;
    @(posedge clk); #1;
    net_tstart = 1'b0; net_valid_in = 1'b1; net_data_in = mk(9, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_net_axis_tvalid !== 1'b1 || net_tx_busy !== 1'b1) begin errors++; $display("FAIL pre_rst: got tvalid=%b busy=%b expected 1 1", m_net_axis_tvalid, net_tx_busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_net_axis_tvalid !== 1'b0 || net_tx_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst: got tvalid=%b rdy=%b expected 0 0", m_net_axis_tvalid, net_tx_rdy); end
    checks++; if (net_tx_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", net_tx_busy); end
    net_valid_in = 1'b0;
    do_reset();
    checks++; if (m_net_axis_tvalid !== 1'b0 || net_tx_busy !== 1'b0) begin errors++; $display("FAIL post_rst: got tvalid=%b busy=%b expected 0 0", m_net_axis_tvalid, net_tx_busy); end
    send_frame(64, 6, -1);
    wait_beats(1);
    if (beats.size() == 1) begin
      checks++;
      if (beats[0].d !== mk(6, 0) || beats[0].k !== {KW{1'b1}} || beats[0].l !== 1'b1) begin
        errors++; $display("FAIL recover: got keep=%h last=%b expected all ones, 1", beats[0].k, beats[0].l);
      end
    end
  endtask

`ifdef NET_TX_STATS_EN
  task automatic test_stats();
    do_reset();
    send_frame(128, 7, -1);
    wait_beats(2);
    m_net_axis_tready = 1'b0;
    fork
      send_frame(128, 8, -1);
      begin repeat (6) @(posedge clk); #1; m_net_axis_tready = 1'b1; end
    join
    wait_beats(4);
    send_frame(128, 10, -1);
    wait_beats(6);
    checks++; if (stat_frames !== 32'd3) begin errors++; $display("FAIL stat_frames: got %0d expected 3", stat_frames); end
    checks++; if (stat_beats !== 32'd6) begin errors++; $display("FAIL stat_beats: got %0d expected 6", stat_beats); end
    checks++; if (stat_stall !== 32'(stall_cnt) || stall_cnt == 0) begin errors++; $display("FAIL stat_stall: got %0d expected %0d", stat_stall, stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_beat();
    test_partial();
    test_backpressure();
    test_zero_len();
    test_err_and_reset();
`ifdef NET_TX_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
